// File: rtl/cache_bus_arbiter_pkg.sv
// Shared types for the instruction/data cache bus arbiter.
// State encoding, owner encoding, latched transfer record and the starvation default.
package cache_bus_arbiter_pkg;

    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    typedef struct packed {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

endpackage

// File: rtl/cache_bus_arbiter_starve_cnt.sv
// Starvation counter and inst-wins decision for the cache bus arbiter.
// Latency: inst_wins is combinational from the request inputs and the count.
// Backpressure: none; the count only moves on a grant.
module arb_starve_cnt
    import cache_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic inst_req,
    input  logic data_req,
    input  logic grant,
    output logic inst_wins
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          starved;

    assign starved   = (cnt_q == LIMIT);
    assign inst_wins = inst_req & (~data_req | starved);

    // Data grants only count against inst while inst is actually waiting.
    always_comb begin
        cnt_d = cnt_q;
        if (grant) begin
            if (inst_wins || !inst_req) begin
                cnt_d = '0;
            end else if (!starved) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Arbitrates I-cache and D-cache misses onto one downstream request/data bus.
// Latency: grant 1 cycle after req in IDLE; dok 1 cycle after the completing bus_data_ok.
// Backpressure: holds in ADDR until bus_addr_ok and in DATA until bus_data_ok, indefinitely.
module cache_bus_arbiter
    import cache_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_dok,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_dok,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    arb_state_t  state_q, state_d;
    owner_t      owner_q, owner_d;
    xfer_t       xfer_q, xfer_d;
    logic        bus_req_q, bus_req_d;
    logic        inst_dok_q, inst_dok_d;
    logic        data_dok_q, data_dok_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;

    logic grant;
    logic inst_wins;
    logic complete;

    assign grant = (state_q == ST_IDLE) & (inst_req | data_req);

    arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .inst_req  (inst_req),
        .data_req  (data_req),
        .grant     (grant),
        .inst_wins (inst_wins)
    );

    // A combined addr_ok+data_ok in ADDR skips DATA entirely.
    assign complete = ((state_q == ST_ADDR) & bus_addr_ok & bus_data_ok) |
                      ((state_q == ST_DATA) & bus_data_ok);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        xfer_d       = xfer_q;
        bus_req_d    = bus_req_q;
        inst_dok_d   = 1'b0;
        data_dok_d   = 1'b0;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d   = ST_ADDR;
                    bus_req_d = 1'b1;
                    if (inst_wins) begin
                        owner_d = OWN_INST;
                        xfer_d  = '{wen: 4'b0, addr: inst_addr, wdata: 32'b0};
                    end else begin
                        owner_d = OWN_DATA;
                        xfer_d  = '{wen: data_wen, addr: data_addr, wdata: data_wdata};
                    end
                end
            end
            ST_ADDR: begin
                if (bus_addr_ok) begin
                    // The latch doubles as the bus drive, so clearing it zeroes the bus.
                    bus_req_d = 1'b0;
                    xfer_d    = '0;
                    state_d   = bus_data_ok ? ST_DONE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus_data_ok) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (complete) begin
            if (owner_q == OWN_DATA) begin
                data_rdata_d = bus_rdata;
                data_dok_d   = 1'b1;
            end else begin
                inst_rdata_d = bus_rdata;
                inst_dok_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_INST;
            xfer_q       <= '0;
            bus_req_q    <= 1'b0;
            inst_dok_q   <= 1'b0;
            data_dok_q   <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            xfer_q       <= xfer_d;
            bus_req_q    <= bus_req_d;
            inst_dok_q   <= inst_dok_d;
            data_dok_q   <= data_dok_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign bus_req    = bus_req_q;
    assign bus_wr     = |xfer_q.wen;
    assign bus_wstrb  = xfer_q.wen;
    assign bus_addr   = xfer_q.addr;
    assign bus_wdata  = xfer_q.wdata;
    assign inst_dok   = inst_dok_q;
    assign data_dok   = data_dok_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Bench for cache_bus_arbiter: directed transfer table, ordering sequences, reset abort,
// then randomized traffic against a request-level arbitration model.
module tb_cache_bus_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_rdata;
    logic        inst_dok;
    logic        data_req = 1'b0;
    logic [3:0]  data_wen = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic        data_dok;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok = 1'b0;
    logic        bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = '0;

    cache_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_rdata  (inst_rdata),
        .inst_dok    (inst_dok),
        .data_req    (data_req),
        .data_wen    (data_wen),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .data_dok    (data_dok),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_wstrb   (bus_wstrb),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vecs = 0;
    int errs = 0;
    logic [31:0] m_inst_rdata = '0;
    logic [31:0] m_data_rdata = '0;
    int          m_starve = 0;

    typedef struct {
        logic        is_data;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          a_dly;
        int          d_dly;
        logic [31:0] rd;
        logic        exp_wr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_bus_req"}, bus_req, 0);
        chk({tag, "_bus_wr_strb"}, {bus_wr, bus_wstrb}, 0);
        chk({tag, "_bus_addr"}, bus_addr, 0);
        chk({tag, "_bus_wdata"}, bus_wdata, 0);
        chk({tag, "_doks"}, {inst_dok, data_dok}, 0);
        chk({tag, "_inst_rdata"}, inst_rdata, m_inst_rdata);
        chk({tag, "_data_rdata"}, data_rdata, m_data_rdata);
    endtask

    // Acts as the downstream bus for one transfer; returns in the IDLE cycle after dok.
    task automatic run_xfer(input logic own, input logic [31:0] ea, input logic [3:0] ew,
                            input logic [31:0] ewd, input logic ewr, input int a_dly,
                            input int d_dly, input logic [31:0] rd, output int dok_cyc);
        int n;
        n = 0;
        dok_cyc = -1;
        while (bus_req !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        chk("grant_seen", bus_req, 1);
        if (bus_req !== 1'b1) return;
        chk("bus_addr", bus_addr, ea);
        chk("bus_wr", bus_wr, ewr);
        chk("bus_wstrb", bus_wstrb, ew);
        chk("bus_wdata", bus_wdata, ewd);
        if (own) begin
            data_addr  = $urandom;
            data_wdata = $urandom;
            data_wen   = 4'($urandom);
        end else begin
            inst_addr = $urandom;
        end
        for (int i = 0; i < a_dly; i++) begin
            bus_data_ok = 1'($urandom);
            bus_rdata   = $urandom;
            step();
            chk("addr_hold", bus_addr, ea);
            chk("wdata_hold", bus_wdata, ewd);
            chk("req_hold", bus_req, 1);
        end
        bus_addr_ok = 1'b1;
        bus_data_ok = (d_dly == 0);
        bus_rdata   = (d_dly == 0) ? rd : $urandom;
        step();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        if (d_dly > 0) begin
            chk("data_phase_ctl", {bus_req, bus_wr, bus_wstrb}, 0);
            chk("data_phase_bus", bus_addr | bus_wdata, 0);
            for (int i = 1; i < d_dly; i++) begin
                chk("dok_early", {inst_dok, data_dok}, 0);
                bus_rdata = $urandom;
                step();
            end
            bus_data_ok = 1'b1;
            bus_rdata   = rd;
            step();
            bus_data_ok = 1'b0;
            bus_rdata   = $urandom;
        end
        if (own) m_data_rdata = rd;
        else     m_inst_rdata = rd;
        chk("inst_dok", inst_dok, !own);
        chk("data_dok", data_dok, own);
        chk("inst_rdata", inst_rdata, m_inst_rdata);
        chk("data_rdata", data_rdata, m_data_rdata);
        chk("done_bus_req", bus_req, 0);
        dok_cyc = cyc;
        if (own) data_req = 1'b0;
        else     inst_req = 1'b0;
        step();
        chk("dok_one_cycle", {inst_dok, data_dok}, 0);
    endtask

    // Arbitration model: data wins ties unless inst has watched LIMIT data grants in a row.
    task automatic do_round(input int a_dly, input int d_dly, output logic own, output int dc);
        logic i_p, d_p, win_inst;
        i_p = inst_req;
        d_p = data_req;
        win_inst = i_p && (!d_p || m_starve == LIMIT);
        own = !win_inst;
        if (own && i_p) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
        else            m_starve = 0;
        if (own) run_xfer(1'b1, data_addr, data_wen, data_wdata, |data_wen, a_dly, d_dly, $urandom, dc);
        else     run_xfer(1'b0, inst_addr, 4'b0, 32'b0, 1'b0, a_dly, d_dly, $urandom, dc);
    endtask

    task automatic raise_inst();
        inst_req  = 1'b1;
        inst_addr = $urandom;
    endtask

    task automatic raise_data(input logic force_write);
        data_req   = 1'b1;
        data_addr  = $urandom;
        data_wdata = $urandom;
        if (force_write)               data_wen = 4'($urandom_range(1, 15));
        else if ($urandom_range(0, 1)) data_wen = 4'($urandom);
        else                           data_wen = 4'b0;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, vectors %0d", vecs);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl[6];
        logic        o1, o2;
        int          dc1, dc2, n, data_left;
        logic [5:0]  ord;

        tbl[0] = '{1'b1, 4'b0000, 32'h0000_1000, 32'h0, 1, 3, 32'hDEAD_BEEF, 1'b0, 4'b0000, 32'h0};
        tbl[1] = '{1'b1, 4'b0011, 32'h0000_2004, 32'h1234_5678, 0, 1, 32'hCAFE_F00D, 1'b1, 4'b0011, 32'h1234_5678};
        tbl[2] = '{1'b0, 4'b0000, 32'h0000_0400, 32'h0, 2, 2, 32'h1357_9BDF, 1'b0, 4'b0000, 32'h0};
        tbl[3] = '{1'b1, 4'b1111, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 0, 0, 32'h0BAD_C0DE, 1'b1, 4'b1111, 32'hFFFF_FFFF};
        tbl[4] = '{1'b0, 4'b0000, 32'h8000_0000, 32'h0, 0, 0, 32'h0123_4567, 1'b0, 4'b0000, 32'h0};
        tbl[5] = '{1'b1, 4'b0000, 32'h0000_3000, 32'h55AA_55AA, 3, 4, 32'h89AB_CDEF, 1'b0, 4'b0000, 32'h55AA_55AA};

        step();
        step();
        chk_quiet("reset");
        rst = 1'b0;
        step();
        chk_quiet("post_reset");

        foreach (tbl[k]) begin
            if (tbl[k].is_data) begin
                data_req   = 1'b1;
                data_wen   = tbl[k].wen;
                data_addr  = tbl[k].addr;
                data_wdata = tbl[k].wdata;
            end else begin
                inst_req  = 1'b1;
                inst_addr = tbl[k].addr;
            end
            run_xfer(tbl[k].is_data, tbl[k].addr, tbl[k].exp_strb, tbl[k].exp_wdata,
                     tbl[k].exp_wr, tbl[k].a_dly, tbl[k].d_dly, tbl[k].rd, dc1);
        end
        m_starve = 0;

        // Simultaneous requests: data first, inst after the tightest possible turnaround.
        inst_req   = 1'b1;
        inst_addr  = 32'h0000_0100;
        data_req   = 1'b1;
        data_wen   = 4'b0;
        data_addr  = 32'h0000_2000;
        data_wdata = 32'h0;
        do_round(0, 0, o1, dc1);
        do_round(0, 0, o2, dc2);
        chk("tie_first_is_data", o1, 1);
        chk("tie_second_is_inst", o2, 0);
        chk("tie_dok_gap_ge3", (dc2 - dc1 >= 3), 1);

        // Starvation: inst held across back-to-back data writes.
        raise_inst();
        raise_data(1'b1);
        data_left = 5;
        ord = '0;
        n = 0;
        while ((data_left > 0 || inst_req) && n < 10) begin
            do_round(0, 1, o1, dc1);
            ord = {ord[4:0], o1};
            n++;
            if (o1) begin
                data_left--;
                if (data_left > 0) raise_data(1'b1);
            end
        end
        chk("starve_rounds", n, 6);
        chk("starve_order", ord, 6'b111101);

        // Reset while waiting in DATA, then a stale data_ok.
        data_req  = 1'b1;
        data_wen  = 4'b0;
        data_addr = 32'h0000_5000;
        n = 0;
        while (bus_req !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        chk("abort_grant_seen", bus_req, 1);
        bus_addr_ok = 1'b1;
        step();
        bus_addr_ok = 1'b0;
        chk("abort_in_data", {bus_req, inst_dok, data_dok}, 0);
        rst      = 1'b1;
        data_req = 1'b0;
        step();
        rst = 1'b0;
        m_inst_rdata = '0;
        m_data_rdata = '0;
        m_starve     = 0;
        chk_quiet("abort_reset");
        bus_data_ok = 1'b1;
        bus_rdata   = 32'hBAD0_BAD0;
        step();
        bus_data_ok = 1'b0;
        chk_quiet("abort_stale_ok");
        step();
        chk_quiet("abort_settle");

        for (int r = 0; r < 200; r++) begin
            if (!inst_req && $urandom_range(0, 9) < 6) raise_inst();
            if (!data_req && $urandom_range(0, 9) < 6) raise_data(1'b0);
            if (!inst_req && !data_req) begin
                if ($urandom_range(0, 1)) raise_inst();
                else                      raise_data(1'b0);
            end
            do_round($urandom_range(0, 3), $urandom_range(0, 4), o1, dc1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
